regfile_access_ctrl: RTL and testbench

Upstream request sequencer for `register_file`. It buffers read and write commands from a valid/ready command port in a small FIFO, then issues them one at a time to `register_file` as single-cycle `we`/`re` pulses. It waits for the matching completion (`read_valid` or `write_resp_valid`) and returns the result on a valid/ready response port. A watchdog converts a missing completion into an error response so the pipeline never hangs.

---
 rtl/regfile_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Brief    : Command FIFO + sequencer issuing one-at-a-time requests to
//            register_file, with a watchdog that turns a lost completion
//            into an error response.
// Revision : 1.0
// ============================================================================
module regfile_access_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [4:0]  rsp_addr,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic        rf_we,
   output logic        rf_re,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_wdata,
   input  logic [31:0] rf_rdata,
   input  logic        rf_busy,
   input  logic        rf_read_valid,
   input  logic        rf_write_resp_valid,
   input  logic [1:0]  rf_write_resp,
   output logic        idle
);

   localparam int c_idx_w = $clog2(DEPTH);
   localparam int c_ptr_w = c_idx_w + 1;
   localparam int c_wd_w  = $clog2(TIMEOUT);
   localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
   localparam logic [c_wd_w-1:0] c_wd_max  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic               r_fifo_write [DEPTH];
   logic [4:0]         r_fifo_addr  [DEPTH];
   logic [31:0]        r_fifo_wdata [DEPTH];

   logic               r_cur_write;
   logic [4:0]         r_cur_addr;
   logic [c_wd_w-1:0]  r_wd;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_start;
   logic w_rd_done;
   logic w_wr_done;
   logic w_timeout;
   logic w_head_write;
   logic [4:0]  w_head_addr;
   logic [31:0] w_head_wdata;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                    (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);

   assign cmd_ready = rst_n && !w_full;
   assign w_push    = cmd_valid && cmd_ready;
   assign w_pop     = (r_state == S_ISSUE);

   assign w_head_write = r_fifo_write[r_rd_ptr[c_idx_w-1:0]];
   assign w_head_addr  = r_fifo_addr[r_rd_ptr[c_idx_w-1:0]];
   assign w_head_wdata = r_fifo_wdata[r_rd_ptr[c_idx_w-1:0]];

   assign w_start   = (r_state == S_IDLE) && (w_next == S_ISSUE);
   assign w_rd_done = (r_state == S_WAIT) && !r_cur_write && rf_read_valid;
   assign w_wr_done = (r_state == S_WAIT) &&  r_cur_write && rf_write_resp_valid;
   assign w_timeout = (r_state == S_WAIT) && (r_wd == c_wd_last);

   assign rsp_valid = (r_state == S_RESP);
   assign idle      = (r_state == S_IDLE) && w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_write[r_wr_ptr[c_idx_w-1:0]] <= cmd_write;
         r_fifo_addr[r_wr_ptr[c_idx_w-1:0]]  <= cmd_addr;
         r_fifo_wdata[r_wr_ptr[c_idx_w-1:0]] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty && !rf_busy) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_rd_done || w_wr_done || w_timeout) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we       <= 1'b0;
         rf_re       <= 1'b0;
         rf_addr     <= '0;
         rf_wdata    <= '0;
         r_cur_write <= 1'b0;
         r_cur_addr  <= '0;
         r_wd        <= '0;
         rsp_write   <= 1'b0;
         rsp_addr    <= '0;
         rsp_rdata   <= '0;
         rsp_status  <= '0;
      end else begin
         rf_we <= w_start &&  w_head_write;
         rf_re <= w_start && !w_head_write;
         if (w_start) begin
            rf_addr     <= w_head_addr;
            rf_wdata    <= w_head_wdata;
            r_cur_write <= w_head_write;
            r_cur_addr  <= w_head_addr;
         end

         if (r_state == S_ISSUE)
            r_wd <= '0;
         else if (r_state == S_WAIT && r_wd != c_wd_max)
            r_wd <= r_wd + 1'b1;

         // A matching completion takes priority over a coincident timeout.
         if (w_rd_done) begin
            rsp_write  <= 1'b0;
            rsp_addr   <= r_cur_addr;
            rsp_rdata  <= rf_rdata;
            rsp_status <= 2'b00;
         end else if (w_wr_done) begin
            rsp_write  <= 1'b1;
            rsp_addr   <= r_cur_addr;
            rsp_rdata  <= '0;
            rsp_status <= rf_write_resp;
         end else if (w_timeout) begin
            rsp_write  <= r_cur_write;
            rsp_addr   <= r_cur_addr;
            rsp_rdata  <= '0;
            rsp_status <= 2'b11;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Brief    : Directed self-checking bench for regfile_access_ctrl.
// Revision : 1.0
// ============================================================================
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic [4:0]  rsp_addr;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        rf_we;
   logic        rf_re;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;
   logic        rf_busy;
   logic        rf_read_valid;
   logic        rf_write_resp_valid;
   logic [1:0]  rf_write_resp;
   logic        idle;

   int n_checks   = 0;
   int n_errors   = 0;
   int n_accepted = 0;
   int n_we       = 0;
   int n_re       = 0;

   always #5 clk = ~clk;

   regfile_access_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_write           (cmd_write),
      .cmd_addr            (cmd_addr),
      .cmd_wdata           (cmd_wdata),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_write           (rsp_write),
      .rsp_addr            (rsp_addr),
      .rsp_rdata           (rsp_rdata),
      .rsp_status          (rsp_status),
      .rf_we               (rf_we),
      .rf_re               (rf_re),
      .rf_addr             (rf_addr),
      .rf_wdata            (rf_wdata),
      .rf_rdata            (rf_rdata),
      .rf_busy             (rf_busy),
      .rf_read_valid       (rf_read_valid),
      .rf_write_resp_valid (rf_write_resp_valid),
      .rf_write_resp       (rf_write_resp),
      .idle                (idle)
   );

   always @(posedge clk) begin
      if (rf_we === 1'b1) n_we++;
      if (rf_re === 1'b1) n_re++;
   end

   // Advance one cycle; sample point is 1 time unit after the rising edge.
   // A command offered while ready is accepted at this edge and withdrawn.
   task automatic tick();
      bit acc;
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         cmd_valid = 1'b0;
         n_accepted++;
      end
   endtask

   task automatic push(input bit w, input logic [4:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
   endtask

   task automatic wait_issue();
      int guard;
      guard = 0;
      while (!(rf_we || rf_re) && guard < 30) begin
         tick();
         guard++;
      end
      n_checks++;
      if (!(rf_we || rf_re)) begin
         n_errors++;
         $display("FAIL issue_wait: no rf_we/rf_re within 30 cycles (required a pulse)");
      end
   endtask

   task automatic issue_and_complete(input bit w, input logic [4:0] a,
                                     input logic [31:0] d, input logic [1:0] st);
      logic [31:0] exp_rdata;
      logic [1:0]  exp_status;
      exp_rdata  = w ? 32'h0 : d;
      exp_status = w ? st : 2'b00;
      wait_issue();
      n_checks++;
      if (rf_we !== w || rf_re !== !w || rf_addr !== a) begin
         n_errors++;
         $display("FAIL issue_req: we=%b re=%b addr=%0d required we=%b re=%b addr=%0d",
                  rf_we, rf_re, rf_addr, w, !w, a);
      end
      if (w) begin
         n_checks++;
         if (rf_wdata !== d) begin
            n_errors++;
            $display("FAIL issue_wdata: got %h required %h", rf_wdata, d);
         end
      end
      tick();
      n_checks++;
      if (rf_we !== 1'b0 || rf_re !== 1'b0 || rf_addr !== a) begin
         n_errors++;
         $display("FAIL pulse_width: we=%b re=%b addr=%0d required 0 0 %0d", rf_we, rf_re, rf_addr, a);
      end
      if (w) begin
         rf_write_resp_valid = 1'b1;
         rf_write_resp       = st;
      end else begin
         rf_read_valid = 1'b1;
         rf_rdata      = d;
      end
      tick();
      rf_write_resp_valid = 1'b0;
      rf_read_valid       = 1'b0;
      rf_rdata            = 32'hDEAD_BEEF;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_write !== w || rsp_addr !== a ||
          rsp_rdata !== exp_rdata || rsp_status !== exp_status) begin
         n_errors++;
         $display("FAIL response: v=%b w=%b a=%0d d=%h s=%b required v=1 w=%b a=%0d d=%h s=%b",
                  rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_status,
                  w, a, exp_rdata, exp_status);
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL handshake: rsp_valid=%b required 0", rsp_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rf_we !== 1'b0 || rf_re !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: ready=%b rsp_valid=%b we=%b re=%b required all 0",
                  cmd_ready, rsp_valid, rf_we, rf_re);
      end
      n_checks++;
      if (rsp_write !== 1'b0 || rsp_addr !== 5'd0 || rsp_rdata !== 32'd0 ||
          rsp_status !== 2'd0 || rf_addr !== 5'd0 || rf_wdata !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_data: rsp w=%b a=%0d d=%h s=%b rf a=%0d d=%h required all 0",
                  rsp_write, rsp_addr, rsp_rdata, rsp_status, rf_addr, rf_wdata);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release: ready=%b idle=%b required 1 1", cmd_ready, idle);
      end
   endtask

   task automatic test_write();
      int we0;
      we0 = n_we;
      push(1'b1, 5'd3, 32'hA0A0_0003);
      n_checks++;
      if (rf_we !== 1'b0 || n_accepted !== 1) begin
         n_errors++;
         $display("FAIL write_accept: we=%b accepted=%0d required 0 1", rf_we, n_accepted);
      end
      tick();
      n_checks++;
      if (rf_we !== 1'b1) begin
         n_errors++;
         $display("FAIL write_latency: rf_we=%b one cycle after accept, required 1", rf_we);
      end
      issue_and_complete(1'b1, 5'd3, 32'hA0A0_0003, 2'b00);
      handshake();
      n_checks++;
      if (n_we - we0 !== 1) begin
         n_errors++;
         $display("FAIL write_pulses: %0d rf_we pulses, required 1", n_we - we0);
      end
   endtask

   task automatic test_read();
      push(1'b0, 5'd3, 32'h0);
      wait_issue();
      tick();
      // A write completion while a read is outstanding must be ignored.
      rf_write_resp_valid = 1'b1;
      rf_write_resp       = 2'b10;
      tick();
      rf_write_resp_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL wrong_type: rsp_valid=%b required 0", rsp_valid);
      end
      rf_read_valid = 1'b1;
      rf_rdata      = 32'hA0A0_0003;
      tick();
      rf_read_valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_addr !== 5'd3 ||
          rsp_rdata !== 32'hA0A0_0003 || rsp_status !== 2'b00) begin
         n_errors++;
         $display("FAIL read_rsp: v=%b w=%b a=%0d d=%h s=%b required 1 0 3 a0a00003 00",
                  rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_status);
      end
      handshake();
   endtask

   task automatic test_fifo_full();
      int acc0;
      acc0 = n_accepted;
      rf_busy = 1'b1;
      for (int i = 0; i < 4; i++)
         push(i[0] == 1'b0, 5'(10 + i), 32'h1000_0000 + 32'(i));
      n_checks++;
      if (n_accepted - acc0 !== 4 || cmd_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL fifo_full: accepted=%0d ready=%b required 4 0", n_accepted - acc0, cmd_ready);
      end
      push(1'b1, 5'd14, 32'h1000_0004);
      n_checks++;
      if (n_accepted - acc0 !== 4 || rf_we !== 1'b0 || rf_re !== 1'b0) begin
         n_errors++;
         $display("FAIL fifo_stall: accepted=%0d we=%b re=%b required 4 0 0",
                  n_accepted - acc0, rf_we, rf_re);
      end
      rf_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         issue_and_complete(i[0] == 1'b0, 5'(10 + i), 32'h1000_0000 + 32'(i), 2'b01);
         handshake();
      end
      n_checks++;
      if (n_accepted - acc0 !== 5 || idle !== 1'b1) begin
         n_errors++;
         $display("FAIL fifo_drain: accepted=%0d idle=%b required 5 1", n_accepted - acc0, idle);
      end
   endtask

   task automatic test_rsp_hold();
      int pulses0;
      push(1'b1, 5'd9, 32'h5555_AAAA);
      push(1'b0, 5'd9, 32'h0);
      issue_and_complete(1'b1, 5'd9, 32'h5555_AAAA, 2'b10);
      pulses0 = n_we + n_re;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_addr !== 5'd9 ||
             rsp_rdata !== 32'd0 || rsp_status !== 2'b10 || rf_we !== 1'b0 || rf_re !== 1'b0) begin
            n_errors++;
            $display("FAIL rsp_hold[%0d]: v=%b w=%b a=%0d d=%h s=%b we=%b re=%b required 1 1 9 0 10 0 0",
                     k, rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_status, rf_we, rf_re);
         end
      end
      n_checks++;
      if (n_we + n_re !== pulses0) begin
         n_errors++;
         $display("FAIL hold_pulses: %0d requests issued while held, required 0", n_we + n_re - pulses0);
      end
      handshake();
      issue_and_complete(1'b0, 5'd9, 32'h5555_AAAA, 2'b00);
      handshake();
   endtask

   task automatic test_timeout();
      push(1'b0, 5'd7, 32'h0);
      push(1'b1, 5'd8, 32'h0BAD_F00D);
      wait_issue();
      n_checks++;
      if (rf_re !== 1'b1 || rf_addr !== 5'd7) begin
         n_errors++;
         $display("FAIL to_issue: re=%b addr=%0d required 1 7", rf_re, rf_addr);
      end
      tick();
      for (int k = 1; k < 8; k++) begin
         tick();
         n_checks++;
         if (rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL to_early: rsp_valid=%b at %0d cycles after WAIT entry, required 0", rsp_valid, k);
         end
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b11 || rsp_rdata !== 32'd0 ||
          rsp_write !== 1'b0 || rsp_addr !== 5'd7) begin
         n_errors++;
         $display("FAIL to_rsp: v=%b s=%b d=%h w=%b a=%0d required 1 11 0 0 7",
                  rsp_valid, rsp_status, rsp_rdata, rsp_write, rsp_addr);
      end
      handshake();
      issue_and_complete(1'b1, 5'd8, 32'h0BAD_F00D, 2'b00);
      handshake();
   endtask

   task automatic test_reset_in_wait();
      int pulses0;
      push(1'b0, 5'd5, 32'h0);
      push(1'b1, 5'd6, 32'h6666_6666);
      wait_issue();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pulses0 = n_we + n_re;
      n_checks++;
      if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_wait: rsp_valid=%b idle=%b required 0 1", rsp_valid, idle);
      end
      rf_read_valid = 1'b1;
      rf_rdata      = 32'h7777_0005;
      tick();
      rf_read_valid = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || idle !== 1'b1 || n_we + n_re !== pulses0) begin
         n_errors++;
         $display("FAIL rst_late: rsp_valid=%b idle=%b new_requests=%0d required 0 1 0",
                  rsp_valid, idle, n_we + n_re - pulses0);
      end
      push(1'b0, 5'd2, 32'h0);
      issue_and_complete(1'b0, 5'd2, 32'h1234_5678, 2'b00);
      handshake();
   endtask

   initial begin
      rst_n               = 1'b0;
      cmd_valid           = 1'b0;
      cmd_write           = 1'b0;
      cmd_addr            = 5'd0;
      cmd_wdata           = 32'd0;
      rsp_ready           = 1'b0;
      rf_rdata            = 32'd0;
      rf_busy             = 1'b0;
      rf_read_valid       = 1'b0;
      rf_write_resp_valid = 1'b0;
      rf_write_resp       = 2'b00;
      test_reset();
      test_write();
      test_read();
      test_fifo_full();
      test_rsp_hold();
      test_timeout();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
`default_nettype wire
